mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//   Shares the single-port memory bus between instruction fetch (I) and load/store (D).
//   D requests come from decode: mem_re/mem_wr qualified by dmem_addr_bus_use.
//   Registered FSM. One transaction is outstanding at a time; completion is on mem_ready.
//   D has priority, with a starvation guard for I. Sits between the fetch/LSU and the memory port.
// PARAMETERS
//   ADDR_W      32  address width
//   DATA_W      32  data width
//   STARVE_MAX  4   max consecutive D grants while I waits (1..15)
// PORTS
//   clk        in   1       clock, rising edge
//   rst        in   1       asynchronous, active-high reset
//   if_req     in   1       fetch request; held until if_ack
//   if_addr    in   ADDR_W  fetch address
//   if_ack     out  1       1-cycle pulse: fetch done, if_rdata valid
//   if_rdata   out  DATA_W  fetched word
//   ls_req     in   1       load/store request; held until ls_ack
//   ls_we      in   1       1=store, 0=load
//   ls_addr    in   ADDR_W  data address
//   ls_wdata   in   DATA_W  store data
//   ls_ack     out  1       1-cycle pulse: load/store done, ls_rdata valid for loads
//   ls_rdata   out  DATA_W  load data
//   mem_req    out  1       bus request; held until mem_ready
//   mem_we     out  1       bus write enable
//   mem_addr   out  ADDR_W  bus address
//   mem_wdata  out  DATA_W  bus write data
//   mem_ready  in   1       memory completes current request this cycle
//   mem_rdata  in   DATA_W  read data, valid with mem_ready
// BEHAVIOUR
//   Reset: state=IDLE, starve_cnt=0.
//     All outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, if_ack, ls_ack, if_rdata, ls_rdata.
//   States: IDLE, BUSY_I, BUSY_D.
//   Grant rule, evaluated in IDLE or in a completing BUSY cycle:
//     only ls_req -> D; only if_req -> I; both -> D unless starve_cnt==STARVE_MAX, then I.
//     The ack'd requester's own req is ignored in its completion cycle.
//   On grant, next edge: state=BUSY_x, mem_req=1, mem_addr/mem_we/mem_wdata latched from the winner.
//     For I, mem_we=0 and mem_wdata=0.
//     Bus outputs are registered and stay stable until mem_ready.
//   BUSY_x with mem_ready=1:
//     - x_ack=1 for exactly 1 cycle (the next cycle).
//     - x_rdata<=mem_rdata. ls_rdata is unchanged on a store ack.
//     - If a new grant exists, the next transaction starts back-to-back (mem_req stays 1).
//       Otherwise return to IDLE with mem_req=0.
//   mem_ready while IDLE: ignored.
//   Latency: req in cycle N (IDLE) -> mem_req in N+1 -> ack in the cycle after mem_ready. Minimum 2 cycles.
//   starve_cnt:
//     - +1 on a D grant while if_req=1, saturating at STARVE_MAX.
//     - Cleared on any I grant.
//     - Cleared when a D grant occurs with if_req=0.
//   rdata regs hold their value between acks. if_ack and ls_ack are never high in the same cycle.
//   Reset mid-transaction: the transaction is abandoned, no ack is issued, and requesters re-request.
//   Requester changing addr/data while waiting: ignored after grant, since the bus uses latched values.
// STRUCTURE
//   Shared package: state encoding (IDLE/BUSY_I/BUSY_D, 2 bits) and the requester-ID enum (REQ_I/REQ_D).
//   Sub-module: arb_prio_starve (2-input fixed-priority picker plus saturating starve counter).
//   Top level holds the FSM and the bus/rdata registers.
// TESTING
//   1. if_req=1, addr=0x100, mem_ready 2 cycles after mem_req, rdata=0xDEADBEEF
//      -> mem_addr=0x100, mem_we=0; if_ack 1 cycle; if_rdata=0xDEADBEEF.
//   2. ls_req+ls_we, addr=0x2000, wdata=0x55AA; if_req simultaneous
//      -> D granted first with mem_we=1, mem_wdata=0x55AA; I granted back-to-back after ls_ack.
//   3. ls_req held for 6 transactions with if_req=1, mem_ready immediate
//      -> 4 D grants, then 1 I grant, then D resumes.
//   4. mem_ready held low for 10 cycles
//      -> mem_req and all bus outputs stable for all 10 cycles; no ack until mem_ready.
//   5. rst asserted while in BUSY_D
//      -> all outputs 0 asynchronously; no ls_ack; a fresh ls_req is serviced normally after rst drops.
//   6. Stray mem_ready=1 while IDLE -> no ack pulses, state stays IDLE.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: FSM state encoding and requester IDs.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_bus_arbiter_arb_prio_starve.sv
// Two-input picker: load/store wins unless fetch has been passed over STARVE_MAX
// times in a row, tracked by a saturating counter updated on every grant.
module arb_prio_starve
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    eval_i,
  input  logic    if_req_i,
  input  logic    ls_req_i,
  output logic    gnt_valid_o,
  output req_id_e gnt_id_o
);

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       starve_sat_s;

  // Priority pick and next starve count.
  always_comb begin
    starve_sat_s = (cnt_q == CNT_MAX);
    gnt_valid_o  = eval_i && (if_req_i || ls_req_i);
    if (ls_req_i && !(if_req_i && starve_sat_s)) begin
      gnt_id_o = REQ_D;
    end else begin
      gnt_id_o = REQ_I;
    end
    cnt_d = cnt_q;
    if (gnt_valid_o) begin
      if ((gnt_id_o == REQ_D) && if_req_i) begin
        cnt_d = starve_sat_s ? cnt_q : (cnt_q + 4'd1);
      end else begin
        cnt_d = 4'd0;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Starve counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D); one transaction
// outstanding, registered bus outputs, 1-cycle acks after mem_ready.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_ack_q;
  logic              ls_ack_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] ls_rdata_q;

  logic              eval_s;
  logic              eff_if_s;
  logic              eff_ls_s;
  logic              gnt_valid_s;
  req_id_e           gnt_id_s;
  state_e            gnt_state_d;
  logic              gnt_we_d;
  logic [ADDR_W-1:0] gnt_addr_d;
  logic [DATA_W-1:0] gnt_wdata_d;

  // Grants are evaluated in IDLE or a completing cycle; the finishing
  // requester still holds req then, so its request is masked.
  always_comb begin
    eval_s   = (state_q == ST_IDLE) || ((state_q != ST_IDLE) && mem_ready);
    eff_if_s = if_req && (state_q != ST_BUSY_I);
    eff_ls_s = ls_req && (state_q != ST_BUSY_D);
  end

  arb_prio_starve #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .eval_i     (eval_s),
    .if_req_i   (eff_if_s),
    .ls_req_i   (eff_ls_s),
    .gnt_valid_o(gnt_valid_s),
    .gnt_id_o   (gnt_id_s)
  );

  // Bus payload of the winning requester.
  always_comb begin
    if (gnt_id_s == REQ_D) begin
      gnt_state_d = ST_BUSY_D;
      gnt_we_d    = ls_we;
      gnt_addr_d  = ls_addr;
      gnt_wdata_d = ls_wdata;
    end else begin
      gnt_state_d = ST_BUSY_I;
      gnt_we_d    = 1'b0;
      gnt_addr_d  = if_addr;
      gnt_wdata_d = {DATA_W{1'b0}};
    end
  end

  // Arbiter FSM with registered bus, ack and read-data outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      if_ack_q    <= 1'b0;
      ls_ack_q    <= 1'b0;
      if_rdata_q  <= {DATA_W{1'b0}};
      ls_rdata_q  <= {DATA_W{1'b0}};
    end else begin
      if_ack_q <= 1'b0;
      ls_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_valid_s) begin
            state_q     <= gnt_state_d;
            mem_req_q   <= 1'b1;
            mem_we_q    <= gnt_we_d;
            mem_addr_q  <= gnt_addr_d;
            mem_wdata_q <= gnt_wdata_d;
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          if (mem_ready) begin
            if (state_q == ST_BUSY_I) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= mem_rdata;
            end else begin
              ls_ack_q <= 1'b1;
              if (!mem_we_q) begin
                ls_rdata_q <= mem_rdata;
              end
            end
            if (gnt_valid_s) begin
              state_q     <= gnt_state_d;
              mem_req_q   <= 1'b1;
              mem_we_q    <= gnt_we_d;
              mem_addr_q  <= gnt_addr_d;
              mem_wdata_q <= gnt_wdata_d;
            end else begin
              state_q   <= ST_IDLE;
              mem_req_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign ls_ack    = ls_ack_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_ack;
  logic [31:0] ls_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, if_ack, ls_ack, if_rdata, ls_rdata} !== 132'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h iack=%b lack=%b irdata=%h lrdata=%h, expected all zero",
               mem_req, mem_we, mem_addr, mem_wdata, if_ack, ls_ack, if_rdata, ls_rdata);
    end
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h0000_0100;
    cyc();
    tests_run++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 32'h100, 32'h0}) begin
      tests_failed++;
      $display("FAIL fetch_grant: got req=%b we=%b addr=%h wdata=%h, expected 1 0 00000100 00000000",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    cyc();
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    cyc();
    tests_run++;
    if ({if_ack, ls_ack, if_rdata, mem_req} !== {1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0}) begin
      tests_failed++;
      $display("FAIL fetch_ack: got iack=%b lack=%b rdata=%h req=%b, expected 1 0 deadbeef 0",
               if_ack, ls_ack, if_rdata, mem_req);
    end
    if_req = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
    cyc();
    tests_run++;
    if ({if_ack, if_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
      tests_failed++;
      $display("FAIL fetch_ack_pulse: got iack=%b rdata=%h, expected 0 deadbeef", if_ack, if_rdata);
    end
  endtask

  task automatic test_back_to_back();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_2000; ls_wdata = 32'h0000_55AA;
    if_req = 1'b1; if_addr = 32'h0000_0300;
    cyc();
    tests_run++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h2000, 32'h55AA}) begin
      tests_failed++;
      $display("FAIL b2b_d_first: got req=%b we=%b addr=%h wdata=%h, expected 1 1 00002000 000055aa",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    mem_ready = 1'b1; mem_rdata = 32'h0000_1234;
    cyc();
    tests_run++;
    if ({ls_ack, if_ack, ls_rdata, mem_req, mem_we, mem_addr, mem_wdata} !==
        {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0}) begin
      tests_failed++;
      $display("FAIL b2b_i_next: got lack=%b iack=%b lrdata=%h req=%b we=%b addr=%h wdata=%h, expected 1 0 0 1 0 300 0",
               ls_ack, if_ack, ls_rdata, mem_req, mem_we, mem_addr, mem_wdata);
    end
    ls_req = 1'b0; mem_rdata = 32'hCAFE_F00D;
    cyc();
    tests_run++;
    if ({if_ack, ls_ack, if_rdata, mem_req} !== {1'b1, 1'b0, 32'hCAFE_F00D, 1'b0}) begin
      tests_failed++;
      $display("FAIL b2b_i_ack: got iack=%b lack=%b rdata=%h req=%b, expected 1 0 cafef00d 0",
               if_ack, ls_ack, if_rdata, mem_req);
    end
    if_req = 1'b0; mem_ready = 1'b0;
    cyc();
  endtask

  task automatic test_starvation();
    logic [31:0] a;
    for (int k = 0; k < 4; k++) begin
      a = 32'h40 + 32'(k * 4);
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = a;
      if_req = 1'b1; if_addr = 32'h0000_0500;
      cyc();
      tests_run++;
      if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, a}) begin
        tests_failed++;
        $display("FAIL starve_d_grant%0d: got req=%b we=%b addr=%h, expected 1 0 %h",
                 k, mem_req, mem_we, mem_addr, a);
      end
      if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h1000 + 32'(k);
      cyc();
      tests_run++;
      if ({ls_ack, ls_rdata, mem_req} !== {1'b1, 32'h1000 + 32'(k), 1'b0}) begin
        tests_failed++;
        $display("FAIL starve_d_ack%0d: got lack=%b rdata=%h req=%b, expected 1 %h 0",
                 k, ls_ack, ls_rdata, mem_req, 32'h1000 + 32'(k));
      end
      ls_req = 1'b0; mem_ready = 1'b0;
    end
    ls_req = 1'b1; ls_addr = 32'h0000_0080; if_req = 1'b1;
    cyc();
    tests_run++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h500}) begin
      tests_failed++;
      $display("FAIL starve_i_wins: got req=%b we=%b addr=%h, expected 1 0 00000500", mem_req, mem_we, mem_addr);
    end
    mem_ready = 1'b1; mem_rdata = 32'h0000_0077;
    cyc();
    tests_run++;
    if ({if_ack, if_rdata, mem_req, mem_addr} !== {1'b1, 32'h77, 1'b1, 32'h80}) begin
      tests_failed++;
      $display("FAIL starve_d_resumes: got iack=%b rdata=%h req=%b addr=%h, expected 1 77 1 80",
               if_ack, if_rdata, mem_req, mem_addr);
    end
    if_req = 1'b0; mem_rdata = 32'h0000_0088;
    cyc();
    tests_run++;
    if ({ls_ack, ls_rdata, mem_req} !== {1'b1, 32'h88, 1'b0}) begin
      tests_failed++;
      $display("FAIL starve_d_done: got lack=%b rdata=%h req=%b, expected 1 88 0", ls_ack, ls_rdata, mem_req);
    end
    ls_req = 1'b0; mem_ready = 1'b0;
    cyc();
  endtask

  task automatic test_stall();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_ABC0; ls_wdata = 32'h0000_0F0F;
    cyc();
    ls_addr = 32'h1111_1111; ls_wdata = 32'h2222_2222; ls_we = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      tests_run++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, if_ack, ls_ack} !==
          {1'b1, 1'b1, 32'hABC0, 32'h0F0F, 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL stall_stable%0d: got req=%b we=%b addr=%h wdata=%h iack=%b lack=%b, expected 1 1 abc0 0f0f 0 0",
                 k, mem_req, mem_we, mem_addr, mem_wdata, if_ack, ls_ack);
      end
    end
    mem_ready = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    cyc();
    tests_run++;
    if ({ls_ack, ls_rdata, mem_req} !== {1'b1, 32'h88, 1'b0}) begin
      tests_failed++;
      $display("FAIL stall_store_ack: got lack=%b rdata=%h req=%b, expected 1 88 0", ls_ack, ls_rdata, mem_req);
    end
    ls_req = 1'b0; mem_ready = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0044; ls_wdata = 32'h0;
    cyc();
    cyc();
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, if_ack, ls_ack, if_rdata, ls_rdata} !== 132'd0) begin
      tests_failed++;
      $display("FAIL reset_async: got req=%b we=%b addr=%h wdata=%h iack=%b lack=%b irdata=%h lrdata=%h, expected all zero",
               mem_req, mem_we, mem_addr, mem_wdata, if_ack, ls_ack, if_rdata, ls_rdata);
    end
    mem_ready = 1'b1; mem_rdata = 32'h0000_0055;
    cyc();
    tests_run++;
    if ({ls_ack, mem_req} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_no_ack: got lack=%b req=%b, expected 0 0", ls_ack, mem_req);
    end
    rst = 1'b0; mem_ready = 1'b0;
    cyc();
    tests_run++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h44}) begin
      tests_failed++;
      $display("FAIL reset_regrant: got req=%b we=%b addr=%h, expected 1 0 44", mem_req, mem_we, mem_addr);
    end
    mem_ready = 1'b1; mem_rdata = 32'h0000_0099;
    cyc();
    tests_run++;
    if ({ls_ack, ls_rdata} !== {1'b1, 32'h99}) begin
      tests_failed++;
      $display("FAIL reset_reserviced: got lack=%b rdata=%h, expected 1 99", ls_ack, ls_rdata);
    end
    ls_req = 1'b0; mem_ready = 1'b0;
    cyc();
  endtask

  task automatic test_stray_ready();
    mem_ready = 1'b1; mem_rdata = 32'h0000_0BAD;
    for (int k = 0; k < 3; k++) begin
      cyc();
      tests_run++;
      if ({if_ack, ls_ack, mem_req, if_rdata, ls_rdata} !== {1'b0, 1'b0, 1'b0, 32'h0, 32'h99}) begin
        tests_failed++;
        $display("FAIL stray_ready%0d: got iack=%b lack=%b req=%b irdata=%h lrdata=%h, expected 0 0 0 0 99",
                 k, if_ack, ls_ack, mem_req, if_rdata, ls_rdata);
      end
    end
    mem_ready = 1'b0;
    if_req = 1'b1; if_addr = 32'h0000_0600;
    cyc();
    tests_run++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h600}) begin
      tests_failed++;
      $display("FAIL stray_still_idle: got req=%b addr=%h, expected 1 600", mem_req, mem_addr);
    end
    mem_ready = 1'b1; mem_rdata = 32'h0000_0123;
    cyc();
    tests_run++;
    if ({if_ack, if_rdata} !== {1'b1, 32'h123}) begin
      tests_failed++;
      $display("FAIL stray_fetch_ack: got iack=%b rdata=%h, expected 1 123", if_ack, if_rdata);
    end
    if_req = 1'b0; mem_ready = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    cyc();
    cyc();
    test_reset();
    rst = 1'b0;
    cyc();
    test_fetch();
    test_back_to_back();
    test_starvation();
    test_stall();
    test_reset_mid();
    test_stray_ready();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
